// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - single-port IMEM arbiter between instruction fetch and loader/debug port
// Loader port and fetch-streak fairness are built only when IMEM_ARB_LOADER_EN is defined.
module imem_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int IF_MAX_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    input  logic                if_kill_i,
    output logic                if_ack_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                ld_req_i,
    input  logic                ld_we_i,
    input  logic [ADDR_W-1:0]   ld_addr_i,
    input  logic [DATA_W-1:0]   ld_wdata_i,
    input  logic [DATA_W/8-1:0] ld_sel_i,
    output logic                ld_ack_o,
    output logic [DATA_W-1:0]   ld_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_sel_o,
    input  logic                mem_ack_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);
    localparam int SEL_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, IF_BUSY, LD_BUSY, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_we;
    logic [DATA_W-1:0] lat_wdata;
    logic [SEL_W-1:0]  lat_sel;
    logic              idle;
    logic              if_win;
    logic              grant;

    assign idle = (state == IDLE);

`ifdef IMEM_ARB_LOADER_EN
    localparam int STREAK_W = $clog2(IF_MAX_STREAK + 1);

    logic [STREAK_W-1:0] streak;
    logic                streak_sat;
    logic                ld_win;

    assign streak_sat = (streak == STREAK_W'(IF_MAX_STREAK));
    assign if_win     = idle && if_req_i && !if_kill_i && !(streak_sat && ld_req_i);
    assign ld_win     = idle && ld_req_i && !if_win;
    assign grant      = if_win || ld_win;

    // Streak only counts fetch grants taken while the loader is actually waiting.
    always_ff @(posedge clk) begin
        if (!rst_n || !ld_req_i || ld_win)
            streak <= '0;
        else if (if_win && !streak_sat)
            streak <= streak + 1'b1;
    end

    assign ld_ack_o   = rst_n && mem_ack_i && (ld_win || state == LD_BUSY);
    assign ld_rdata_o = mem_rdata_i;
`else
    logic unused_ld;

    assign unused_ld  = ^{ld_req_i, ld_we_i, ld_addr_i, ld_wdata_i, ld_sel_i};
    assign if_win     = idle && if_req_i && !if_kill_i;
    assign grant      = if_win;
    assign ld_ack_o   = 1'b0;
    assign ld_rdata_o = '0;
`endif

    assign if_ack_o   = rst_n && mem_ack_i && (if_win || (state == IF_BUSY && !if_kill_i));
    assign if_rdata_o = mem_rdata_i;

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = lat_addr;
        mem_wdata_o = lat_wdata;
        mem_sel_o   = lat_sel;
        if (!rst_n) begin
            mem_addr_o  = '0;
            mem_wdata_o = '0;
            mem_sel_o   = '0;
        end else if (!idle) begin
            mem_req_o = 1'b1;
            mem_we_o  = lat_we;
        end else if (if_win) begin
            mem_req_o   = 1'b1;
            mem_addr_o  = if_addr_i;
            mem_wdata_o = '0;
            mem_sel_o   = '1;
        end
`ifdef IMEM_ARB_LOADER_EN
        else if (ld_win) begin
            mem_req_o   = 1'b1;
            mem_we_o    = ld_we_i;
            mem_addr_o  = ld_addr_i;
            mem_wdata_o = ld_wdata_i;
            mem_sel_o   = ld_sel_i;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            lat_sel   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Capture the winner's request so later requester changes cannot disturb it.
                    if (grant && !mem_ack_i) begin
                        lat_addr  <= mem_addr_o;
                        lat_we    <= mem_we_o;
                        lat_wdata <= mem_wdata_o;
                        lat_sel   <= mem_sel_o;
`ifdef IMEM_ARB_LOADER_EN
                        state     <= if_win ? IF_BUSY : LD_BUSY;
`else
                        state     <= IF_BUSY;
`endif
                    end
                end
                IF_BUSY: begin
                    if (mem_ack_i)
                        state <= IDLE;
                    else if (if_kill_i)
                        state <= DRAIN;
                end
                default: begin
                    if (mem_ack_i)
                        state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - scoreboard bench for imem_arbiter (loader tests when IMEM_ARB_LOADER_EN is defined)
module tb_imem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_i, if_kill_i, if_ack_o;
    logic [31:0] if_addr_i, if_rdata_o;
    logic        ld_req_i, ld_we_i, ld_ack_o;
    logic [31:0] ld_addr_i, ld_wdata_i, ld_rdata_o;
    logic [3:0]  ld_sel_i, mem_sel_o;
    logic        mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    logic        zero_wait;
    logic        ack_pulse;
    logic [31:0] if_q[$];
    logic [31:0] ld_q[$];
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    imem_arbiter #(.ADDR_W(32), .DATA_W(32), .IF_MAX_STREAK(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_kill_i(if_kill_i),
        .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
        .ld_req_i(ld_req_i), .ld_we_i(ld_we_i), .ld_addr_i(ld_addr_i),
        .ld_wdata_i(ld_wdata_i), .ld_sel_i(ld_sel_i),
        .ld_ack_o(ld_ack_o), .ld_rdata_o(ld_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_sel_o(mem_sel_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    function automatic logic [31:0] rd_pat(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction

    // Memory model: zero-wait acks any request immediately, otherwise the bench pulses the ack.
    always_comb begin
        mem_ack_i   = zero_wait ? mem_req_o : ack_pulse;
        mem_rdata_i = rd_pat(mem_addr_o);
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; zero_wait = 1'b0; ack_pulse = 1'b1;
        if_req_i = 1'b1; if_addr_i = 32'h44; if_kill_i = 1'b0;
        ld_req_i = 1'b1; ld_we_i = 1'b1; ld_addr_i = 32'h88; ld_wdata_i = 32'h1234; ld_sel_i = 4'hF;
        @(negedge clk);
        n_chk++; if (mem_req_o !== 1'b0) $display("FAIL rst_mem_req got=%0h exp=0", mem_req_o); else n_pass++;
        n_chk++; if (if_ack_o !== 1'b0) $display("FAIL rst_if_ack got=%0h exp=0", if_ack_o); else n_pass++;
        n_chk++; if (ld_ack_o !== 1'b0) $display("FAIL rst_ld_ack got=%0h exp=0", ld_ack_o); else n_pass++;
        next_cyc();
        n_chk++; if (mem_addr_o !== 32'h0) $display("FAIL rst_mem_addr got=%0h exp=0", mem_addr_o); else n_pass++;
        rst_n = 1'b1; ack_pulse = 1'b0; if_req_i = 1'b0; ld_req_i = 1'b0; ld_we_i = 1'b0;
        @(negedge clk);
        n_chk++; if (mem_req_o !== 1'b0) $display("FAIL post_rst_idle got=%0h exp=0", mem_req_o); else n_pass++;
        next_cyc();
    endtask

    task automatic test_zero_wait_fetch();
        logic [31:0] exp;
        zero_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_req_i = 1'b1; if_addr_i = 32'(i * 4);
            if_q.push_back(rd_pat(if_addr_i));
            @(negedge clk);
            n_chk++; if (mem_addr_o !== 32'(i * 4)) $display("FAIL zw_addr got=%0h exp=%0h", mem_addr_o, i * 4); else n_pass++;
            n_chk++; if (if_ack_o !== 1'b1) $display("FAIL zw_ack got=%0h exp=1", if_ack_o); else n_pass++;
            if (if_ack_o === 1'b1 && if_q.size() > 0) begin
                exp = if_q.pop_front();
                n_chk++; if (if_rdata_o !== exp) $display("FAIL zw_rdata got=%0h exp=%0h", if_rdata_o, exp); else n_pass++;
            end
            next_cyc();
        end
        if_req_i = 1'b0;
    endtask

    task automatic test_wait_fetch();
        logic [31:0] exp;
        int acks = 0;
        zero_wait = 1'b0; ack_pulse = 1'b0;
        if_req_i = 1'b1; if_addr_i = 32'h100;
        if_q.push_back(rd_pat(32'h100));
        for (int c = 0; c < 4; c++) begin
            if (c == 1) if_addr_i = 32'h200;
            if (c == 3) if_req_i = 1'b0;
            ack_pulse = (c == 2);
            @(negedge clk);
            if (c < 3) begin
                n_chk++; if (mem_addr_o !== 32'h100) $display("FAIL wait_addr_hold c=%0d got=%0h exp=100", c, mem_addr_o); else n_pass++;
            end
            n_chk++; if (mem_req_o !== (c < 3)) $display("FAIL wait_req c=%0d got=%0h exp=%0h", c, mem_req_o, c < 3); else n_pass++;
            if (if_ack_o === 1'b1) begin
                acks++;
                if (if_q.size() > 0) begin
                    exp = if_q.pop_front();
                    n_chk++; if (if_rdata_o !== exp) $display("FAIL wait_rdata got=%0h exp=%0h", if_rdata_o, exp); else n_pass++;
                end
            end
            next_cyc();
        end
        ack_pulse = 1'b0;
        n_chk++; if (acks !== 1) $display("FAIL wait_ack_count got=%0d exp=1", acks); else n_pass++;
    endtask

    task automatic test_kill_drain();
        logic [31:0] exp;
        zero_wait = 1'b0; ack_pulse = 1'b0;
        if_req_i = 1'b1; if_addr_i = 32'h40;
        next_cyc();
        if_kill_i = 1'b1; if_req_i = 1'b0; if_addr_i = 32'h80;
        @(negedge clk);
        n_chk++; if (if_ack_o !== 1'b0) $display("FAIL kill_ack got=%0h exp=0", if_ack_o); else n_pass++;
        next_cyc();
        if_kill_i = 1'b0; if_req_i = 1'b1;
        if_q.push_back(rd_pat(32'h80));
        @(negedge clk);
        n_chk++; if (mem_addr_o !== 32'h40) $display("FAIL drain_addr got=%0h exp=40", mem_addr_o); else n_pass++;
        n_chk++; if (mem_req_o !== 1'b1) $display("FAIL drain_req got=%0h exp=1", mem_req_o); else n_pass++;
        next_cyc();
        ack_pulse = 1'b1;
        @(negedge clk);
        n_chk++; if (if_ack_o !== 1'b0) $display("FAIL drain_ack_swallow got=%0h exp=0", if_ack_o); else n_pass++;
        next_cyc();
        @(negedge clk);
        n_chk++; if (mem_addr_o !== 32'h80) $display("FAIL post_drain_addr got=%0h exp=80", mem_addr_o); else n_pass++;
        n_chk++; if (if_ack_o !== 1'b1) $display("FAIL post_drain_ack got=%0h exp=1", if_ack_o); else n_pass++;
        if (if_ack_o === 1'b1 && if_q.size() > 0) begin
            exp = if_q.pop_front();
            n_chk++; if (if_rdata_o !== exp) $display("FAIL post_drain_rdata got=%0h exp=%0h", if_rdata_o, exp); else n_pass++;
        end
        next_cyc();
        ack_pulse = 1'b0; if_req_i = 1'b0;
    endtask

    task automatic test_kill_ack_same_cycle();
        zero_wait = 1'b0; ack_pulse = 1'b0;
        if_req_i = 1'b1; if_addr_i = 32'h40;
        next_cyc();
        if_kill_i = 1'b1; if_req_i = 1'b0; ack_pulse = 1'b1;
        @(negedge clk);
        n_chk++; if (if_ack_o !== 1'b0) $display("FAIL kill_same_ack got=%0h exp=0", if_ack_o); else n_pass++;
        next_cyc();
        if_kill_i = 1'b0; ack_pulse = 1'b0;
        @(negedge clk);
        n_chk++; if (mem_req_o !== 1'b0) $display("FAIL kill_same_idle got=%0h exp=0", mem_req_o); else n_pass++;
        next_cyc();
    endtask

`ifdef IMEM_ARB_LOADER_EN
    task automatic test_reset_ld_busy();
        logic [31:0] exp;
        zero_wait = 1'b0; ack_pulse = 1'b0;
        ld_req_i = 1'b1; ld_we_i = 1'b0; ld_addr_i = 32'h90;
        @(negedge clk);
        n_chk++; if (mem_addr_o !== 32'h90) $display("FAIL ldbusy_addr got=%0h exp=90", mem_addr_o); else n_pass++;
        next_cyc();
        rst_n = 1'b0; ld_req_i = 1'b0;
        @(negedge clk);
        n_chk++; if (mem_req_o !== 1'b0) $display("FAIL ldrst_req got=%0h exp=0", mem_req_o); else n_pass++;
        next_cyc();
        rst_n = 1'b1; ack_pulse = 1'b1;
        @(negedge clk);
        n_chk++; if (ld_ack_o !== 1'b0) $display("FAIL late_ack_ld got=%0h exp=0", ld_ack_o); else n_pass++;
        n_chk++; if (mem_req_o !== 1'b0) $display("FAIL late_ack_idle got=%0h exp=0", mem_req_o); else n_pass++;
        next_cyc();
        ack_pulse = 1'b0; zero_wait = 1'b1; if_req_i = 1'b1; if_addr_i = 32'hC;
        if_q.push_back(rd_pat(32'hC));
        @(negedge clk);
        n_chk++; if (if_ack_o !== 1'b1) $display("FAIL post_rst_fetch got=%0h exp=1", if_ack_o); else n_pass++;
        if (if_ack_o === 1'b1 && if_q.size() > 0) begin
            exp = if_q.pop_front();
            n_chk++; if (if_rdata_o !== exp) $display("FAIL post_rst_rdata got=%0h exp=%0h", if_rdata_o, exp); else n_pass++;
        end
        next_cyc();
        if_req_i = 1'b0;
    endtask

    task automatic test_streak();
        logic [31:0] pc = 32'h10;
        logic [31:0] exp;
        logic        exp_l;
        zero_wait = 1'b1;
        ld_we_i = 1'b1; ld_addr_i = 32'h80; ld_wdata_i = 32'hDEADBEEF; ld_sel_i = 4'hF;
        // Cycle 13 withdraws the loader request, which must restart the streak from zero.
        for (int i = 0; i < 19; i++) begin
            if_req_i = 1'b1; if_addr_i = pc;
            ld_req_i = (i != 13);
            exp_l = (i == 4 || i == 9 || i == 18);
            if (exp_l) ld_q.push_back(rd_pat(32'h80));
            else if_q.push_back(rd_pat(pc));
            @(negedge clk);
            n_chk++; if (if_ack_o !== !exp_l) $display("FAIL streak_if_ack i=%0d got=%0h exp=%0h", i, if_ack_o, !exp_l); else n_pass++;
            n_chk++; if (ld_ack_o !== exp_l) $display("FAIL streak_ld_ack i=%0d got=%0h exp=%0h", i, ld_ack_o, exp_l); else n_pass++;
            if (exp_l) begin
                n_chk++; if ({mem_we_o, mem_addr_o, mem_wdata_o, mem_sel_o} !== {1'b1, 32'h80, 32'hDEADBEEF, 4'hF})
                    $display("FAIL ld_write_bus i=%0d got=%0h/%0h/%0h/%0h exp=1/80/deadbeef/f", i, mem_we_o, mem_addr_o, mem_wdata_o, mem_sel_o); else n_pass++;
            end else begin
                n_chk++; if ({mem_we_o, mem_addr_o, mem_wdata_o, mem_sel_o} !== {1'b0, pc, 32'h0, 4'hF})
                    $display("FAIL fetch_bus i=%0d got=%0h/%0h/%0h/%0h exp=0/%0h/0/f", i, mem_we_o, mem_addr_o, mem_wdata_o, mem_sel_o, pc); else n_pass++;
            end
            if (if_ack_o === 1'b1 && if_q.size() > 0) begin
                exp = if_q.pop_front();
                n_chk++; if (if_rdata_o !== exp) $display("FAIL streak_if_rdata i=%0d got=%0h exp=%0h", i, if_rdata_o, exp); else n_pass++;
            end
            if (ld_ack_o === 1'b1 && ld_q.size() > 0) begin
                exp = ld_q.pop_front();
                n_chk++; if (ld_rdata_o !== exp) $display("FAIL streak_ld_rdata i=%0d got=%0h exp=%0h", i, ld_rdata_o, exp); else n_pass++;
            end
            next_cyc();
            if (!exp_l) pc = pc + 32'h4;
        end
        if_req_i = 1'b0; ld_req_i = 1'b0; ld_we_i = 1'b0;
    endtask
`else
    task automatic test_no_loader();
        logic [31:0] exp;
        zero_wait = 1'b1;
        ld_req_i = 1'b1; ld_we_i = 1'b1; ld_addr_i = 32'h80; ld_wdata_i = 32'hDEADBEEF; ld_sel_i = 4'hF;
        @(negedge clk);
        n_chk++; if (mem_req_o !== 1'b0) $display("FAIL noldr_req got=%0h exp=0", mem_req_o); else n_pass++;
        n_chk++; if (ld_ack_o !== 1'b0) $display("FAIL noldr_ld_ack got=%0h exp=0", ld_ack_o); else n_pass++;
        next_cyc();
        for (int i = 0; i < 3; i++) begin
            if_req_i = 1'b1; if_addr_i = 32'h20 + 32'(i * 4);
            if_q.push_back(rd_pat(if_addr_i));
            @(negedge clk);
            n_chk++; if ({mem_we_o, mem_addr_o, mem_sel_o} !== {1'b0, 32'h20 + 32'(i * 4), 4'hF})
                $display("FAIL noldr_bus i=%0d got=%0h/%0h/%0h exp=0/%0h/f", i, mem_we_o, mem_addr_o, mem_sel_o, 32'h20 + i * 4); else n_pass++;
            n_chk++; if ({if_ack_o, ld_ack_o} !== 2'b10) $display("FAIL noldr_acks i=%0d got=%0b exp=10", i, {if_ack_o, ld_ack_o}); else n_pass++;
            n_chk++; if (ld_rdata_o !== 32'h0) $display("FAIL noldr_ld_rdata i=%0d got=%0h exp=0", i, ld_rdata_o); else n_pass++;
            if (if_ack_o === 1'b1 && if_q.size() > 0) begin
                exp = if_q.pop_front();
                n_chk++; if (if_rdata_o !== exp) $display("FAIL noldr_rdata i=%0d got=%0h exp=%0h", i, if_rdata_o, exp); else n_pass++;
            end
            next_cyc();
        end
        if_req_i = 1'b0; ld_req_i = 1'b0; ld_we_i = 1'b0;
    endtask
`endif

    task automatic test_scoreboard_drained();
        n_chk++; if (if_q.size() !== 0) $display("FAIL if_queue_left got=%0d exp=0", if_q.size()); else n_pass++;
        n_chk++; if (ld_q.size() !== 0) $display("FAIL ld_queue_left got=%0d exp=0", ld_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_zero_wait_fetch();
        test_wait_fetch();
        test_kill_drain();
        test_kill_ack_same_cycle();
`ifdef IMEM_ARB_LOADER_EN
        test_reset_ld_busy();
        test_streak();
`else
        test_no_loader();
`endif
        test_scoreboard_drained();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single-ported instruction memory between the fetch unit and a secondary loader/debug port that writes program images and reads code words. Sits between the fetch stage's IMEM request/response interface and the memory macro. Fetch has priority by default, with a bounded streak counter guaranteeing loader progress. Outstanding accesses are tracked, and a fetch access killed by a redirect is drained without returning data.

## Interface
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- IF_MAX_STREAK, 4, consecutive fetch grants allowed while loader waits (≥1)

- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- if_req_i  in  1  fetch request (already deasserted by fetch on kill)
- if_addr_i  in  ADDR_W  fetch address (PC)
- if_kill_i  in  1  redirect pending; abandon current fetch access
- if_ack_o  out  1  fetch access complete
- if_rdata_o  out  DATA_W  fetched word, valid with if_ack_o
- ld_req_i, ld_we_i  in  1  loader request / write enable
- ld_addr_i  in  ADDR_W  loader address
- ld_wdata_i  in  DATA_W  loader write data
- ld_sel_i  in  DATA_W/8  loader byte enables
- ld_ack_o  out  1  loader access complete
- ld_rdata_o  out  DATA_W  loader read data, valid with ld_ack_o
- mem_req_o, mem_we_o  out  1  memory request / write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o, mem_sel_o  out  DATA_W, DATA_W/8  write data / byte enables (fetch: 0 / all ones)
- mem_ack_i  in  1  memory completion; may arrive same cycle as request
- mem_rdata_i  in  DATA_W  memory read data

## Operation
- States: IDLE, IF_BUSY, LD_BUSY, DRAIN.
- IDLE: grant computed combinationally. Winner's address, data, and controls are forwarded to memory in the same cycle.
  - Fetch wins if if_req_i and ~if_kill_i, unless streak == IF_MAX_STREAK and ld_req_i; then the loader wins.
- Grant with mem_ack_i in the same cycle: ack and rdata route to the winner the same cycle; stay IDLE.
- Grant without ack: latch owner, addr, we, wdata, and sel into registers; go to IF_BUSY or LD_BUSY.
- BUSY states:
  - mem_* outputs driven from latched registers with mem_req_o held at 1, so requester changes are ignored.
  - On mem_ack_i: ack the owner, return to IDLE.
- IF_BUSY with if_kill_i and no mem_ack_i: go to DRAIN. If mem_ack_i arrives in the kill cycle: no if_ack_o, return to IDLE.
- DRAIN: mem_req_o held; mem_ack_i consumed silently (no if_ack_o, no ld_ack_o); then IDLE.
- Streak counter, saturating at IF_MAX_STREAK:
  - +1 per fetch grant while ld_req_i is high.
  - Cleared on loader grant or when ld_req_i is low.
- Acks are never issued to a non-owner. rdata outputs pass mem_rdata_i unconditionally.

## Timing
- Zero-wait memory: 0-cycle latency, one access per cycle, fetch back-to-back with no bubble.
- Wait-state memory: latency = memory latency. Re-arbitration occurs in the cycle after ack (IDLE), giving a 1-cycle turnaround on the memory.
- During rst_n low: mem_req_o, if_ack_o, ld_ack_o forced 0.
- Reset values: state=IDLE, streak=0, latched regs=0, mem_addr_o=0.
- Reset mid-access: outstanding access abandoned; any later mem_ack_i arriving in IDLE with no request is ignored.
- Simultaneous if_req_i and ld_req_i in IDLE: fetch wins unless streak is saturated.
- Loader request withdrawn before grant: counter clears; no access issued.

## Configuration
- IMEM_ARB_LOADER_EN defined: full loader port and streak logic as above.
- Not defined:
  - Loader inputs ignored; ld_ack_o=0, ld_rdata_o=0; LD_BUSY and streak logic removed.
  - Block reduces to fetch pass-through with kill/DRAIN handling. mem_we_o=0.

## Test plan
- Zero-wait memory, if_req_i held, PCs 0x0,0x4,0x8 → mem_addr_o follows PC each cycle, if_ack_o=1 every cycle, if_rdata_o=mem_rdata_i.
- 2-wait memory, fetch 0x100, if_addr_i changed to 0x200 mid-access → mem_addr_o stays 0x100 until ack; if_ack_o exactly once.
- IF_BUSY at 0x40, if_kill_i pulse, ack 2 cycles later → no if_ack_o; next grant only after ack; the new fetch address is issued in the following cycle.
- if_req_i and ld_req_i both held, zero-wait, IF_MAX_STREAK=4 → grant pattern F,F,F,F,L repeating; loader write of 0xDEADBEEF to 0x80 with ld_sel_i=0xF is seen on mem_* outputs.
- rst_n low during LD_BUSY, then mem_ack_i arrives after reset → ld_ack_o=0, state IDLE, streak=0.
- Macro undefined, ld_req_i=1 → no loader access, ld_ack_o=0, fetch unaffected.
